ball_dir_ctrl: RTL and testbench

BALL_DIR_CTRL -- requirements
Module: ball_dir_ctrl

---
 rtl/ball_pkg.sv | 14 +
 rtl/ball_dir_ctrl_step_divider.sv | 33 +++
 rtl/ball_dir_ctrl.sv | 115 +++++++++++
 tb/tb_ball_dir_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and screen/divider constants for the ball direction controller.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOST = 2'd2
  } ball_state_t;

  localparam int X_MAX_DEF = 639;
  localparam int Y_MAX_DEF = 479;
  localparam int DIV_W     = 24;

endpackage

// File: rtl/ball_dir_ctrl_step_divider.sv
// Step divider: counts 0..div-1 while run is high and emits a one-cycle tick at div-1.
module step_divider
  import ball_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a shortened period mid-count still wraps immediately
  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (run) begin
      if (cnt_q >= div - 1'b1) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_dir_ctrl.sv
// Ball direction controller: launch/run/lost FSM, wall/paddle/brick direction updates.
// Optional BALL_SPEEDUP_EN: each paddle hit shortens the step period down to STEP_DIV/4.
module ball_dir_ctrl
  import ball_pkg::*;
#(
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int PADDLE_Y = 460,
  parameter int PADDLE_W = 64,
  parameter int STEP_DIV = 250000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       launch,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_x,
  input  logic       brick_hit,
  input  logic       brick_side,
  output logic       move_en,
  output logic       x_du,
  output logic       y_du,
  output logic       ball_lost,
  output logic       running
);

  localparam logic [9:0]       X_LIM    = 10'(X_MAX);
  localparam logic [9:0]       Y_LIM    = 10'(Y_MAX);
  localparam logic [9:0]       PAD_ROW  = 10'(PADDLE_Y - 1);
  localparam logic [10:0]      PAD_W_M1 = 11'(PADDLE_W - 1);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(STEP_DIV);
`ifdef BALL_SPEEDUP_EN
  localparam logic [DIV_W-1:0] DIV_DEC  = DIV_W'(STEP_DIV / 8);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(STEP_DIV / 4);
`endif

  ball_state_t      state_q, state_d;
  logic             x_du_q, x_du_d;
  logic             y_du_q, y_du_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             paddle_hit;
  logic [10:0]      bx_ext, px_ext;

  // Widened so paddle_x + PADDLE_W - 1 cannot wrap past 1023
  assign bx_ext = {1'b0, ball_x};
  assign px_ext = {1'b0, paddle_x};

  always_comb begin
    state_d    = state_q;
    x_du_d     = x_du_q;
    y_du_d     = y_du_q;
    div_d      = div_q;
    running    = 1'b0;
    ball_lost  = 1'b0;
    paddle_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_RUN;
          x_du_d  = 1'b1;
          y_du_d  = 1'b0;
          div_d   = DIV_FULL;
        end
      end
      ST_RUN: begin
        running    = 1'b1;
        paddle_hit = y_du_q && (ball_y == PAD_ROW) &&
                     (bx_ext >= px_ext) && (bx_ext <= px_ext + PAD_W_M1);
        // Walls and paddle override a brick toggle on the same axis
        if (ball_x == 10'd0)                x_du_d = 1'b1;
        else if (ball_x >= X_LIM)           x_du_d = 1'b0;
        else if (brick_hit && brick_side)   x_du_d = ~x_du_q;
        if (ball_y == 10'd0)                y_du_d = 1'b1;
        else if (paddle_hit)                y_du_d = 1'b0;
        else if (brick_hit && !brick_side)  y_du_d = ~y_du_q;
`ifdef BALL_SPEEDUP_EN
        if (paddle_hit)
          div_d = (div_q >= DIV_MIN + DIV_DEC) ? div_q - DIV_DEC : DIV_MIN;
`endif
        if (ball_y >= Y_LIM) state_d = ST_LOST;
      end
      ST_LOST: begin
        ball_lost = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      x_du_q  <= 1'b1;
      y_du_q  <= 1'b0;
      div_q   <= DIV_FULL;
    end else begin
      state_q <= state_d;
      x_du_q  <= x_du_d;
      y_du_q  <= y_du_d;
      div_q   <= div_d;
    end
  end

  step_divider u_step_divider (
    .clk    (clk),
    .resetn (resetn),
    .run    (state_q == ST_RUN),
    .div    (div_q),
    .tick   (move_en)
  );

  assign x_du = x_du_q;
  assign y_du = y_du_q;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Bench for ball_dir_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_ball_dir_ctrl;

`ifdef BALL_SPEEDUP_EN
  localparam int STEP = 64;
`else
  localparam int STEP = 4;
`endif
  localparam int PAD_Y = 460;
  localparam int PAD_W = 64;
  localparam int XM    = 639;
  localparam int YM    = 479;

  logic       clk = 1'b0;
  logic       resetn, launch, brick_hit, brick_side;
  logic [9:0] ball_x, ball_y, paddle_x;
  logic       move_en, x_du, y_du, ball_lost, running;
  logic [4:0] dvec;

  always #5 clk = ~clk;

  ball_dir_ctrl #(.STEP_DIV(STEP)) dut (
    .clk(clk), .resetn(resetn), .launch(launch),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x),
    .brick_hit(brick_hit), .brick_side(brick_side),
    .move_en(move_en), .x_du(x_du), .y_du(y_du),
    .ball_lost(ball_lost), .running(running)
  );

  assign dvec = {running, move_en, x_du, y_du, ball_lost};

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode 0 idle, 1 run, 2 lost; cyc = cycles into current step period
  int m_state = 0, m_xdu = 1, m_ydu = 0, m_div = STEP, m_cyc = 0;

  task automatic model_edge();
    int x, y, px;
    bit hit;
    x = ball_x; y = ball_y; px = paddle_x;
    if (!resetn) begin
      m_state = 0; m_xdu = 1; m_ydu = 0; m_div = STEP; m_cyc = 0;
      return;
    end
    case (m_state)
      0: if (launch) begin
        m_state = 1; m_xdu = 1; m_ydu = 0; m_div = STEP;
      end
      1: begin
        hit = (m_ydu == 1) && (y == PAD_Y - 1) && (x >= px) && (x <= px + PAD_W - 1);
        m_cyc = (m_cyc + 1 >= m_div) ? 0 : m_cyc + 1;
        if (x == 0) m_xdu = 1;
        else if (x >= XM) m_xdu = 0;
        else if (brick_hit && brick_side) m_xdu = 1 - m_xdu;
        if (y == 0) m_ydu = 1;
        else if (hit) m_ydu = 0;
        else if (brick_hit && !brick_side) m_ydu = 1 - m_ydu;
`ifdef BALL_SPEEDUP_EN
        if (hit) m_div = (m_div - STEP / 8 < STEP / 4) ? STEP / 4 : m_div - STEP / 8;
`endif
        if (y >= YM) m_state = 2;
      end
      default: m_state = 0;
    endcase
    if (m_state != 1) m_cyc = 0;
  endtask

  function automatic logic [4:0] m_vec();
    logic r, me, l;
    r  = (m_state == 1);
    me = (m_state == 1) && (m_cyc == m_div - 1);
    l  = (m_state == 2);
    return {r, me, m_xdu[0], m_ydu[0], l};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_inputs();
    launch = 0; brick_hit = 0; brick_side = 0;
    ball_x = 10'd300; ball_y = 10'd200; paddle_x = 10'd0;
  endtask

  task automatic test_reset();
    resetn = 0; quiet_inputs();
    step(); step();
    resetn = 1;
    n_cmp++;
    if (dvec !== 5'b00100) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", dvec, 5'b00100);
    end
    n_cmp++;
    if (dvec !== m_vec()) begin
      n_bad++; $display("FAIL reset_model: got %b want %b", dvec, m_vec());
    end
  endtask

  task automatic test_launch();
    int pulses, last, cyc;
    repeat (2) step();
    launch = 1; step(); launch = 0;
    n_cmp++;
    if ({running, x_du, y_du} !== 3'b110) begin
      n_bad++; $display("FAIL launch_run: got %b want %b", {running, x_du, y_du}, 3'b110);
    end
    pulses = 0; last = -1;
    for (int k = 1; k <= 4 * STEP; k++) begin
      step();
      n_cmp++;
      if (dvec !== m_vec()) begin
        n_bad++; $display("FAIL launch_model k=%0d: got %b want %b", k, dvec, m_vec());
      end
      if (move_en) begin
        if (last >= 0) begin
          n_cmp++;
          if (k - last != STEP) begin
            n_bad++; $display("FAIL step_period: got %0d want %0d", k - last, STEP);
          end
        end
        last = k; pulses++;
      end
    end
    cyc = pulses;
    n_cmp++;
    if (cyc != 4) begin
      n_bad++; $display("FAIL step_pulses: got %0d want 4", cyc);
    end
  endtask

  task automatic test_walls();
    ball_x = 10'd639; step();
    n_cmp++;
    if (x_du !== 1'b0 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL wall_right: got %b want x_du=0 (%b)", dvec, m_vec());
    end
    ball_x = 10'd0; step();
    n_cmp++;
    if (x_du !== 1'b1 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL wall_left: got %b want x_du=1 (%b)", dvec, m_vec());
    end
    ball_x = 10'd300;
  endtask

  task automatic test_paddle();
    ball_y = 10'd0; step();
    ball_y = 10'd459; paddle_x = 10'd600; ball_x = 10'd630; step();
    n_cmp++;
    if (y_du !== 1'b0 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL paddle_hit: got %b want y_du=0 (%b)", dvec, m_vec());
    end
    ball_y = 10'd0; step();
    ball_y = 10'd459; ball_x = 10'd670; step();
    n_cmp++;
    if (y_du !== 1'b1 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL paddle_miss: got %b want y_du=1 (%b)", dvec, m_vec());
    end
    paddle_x = 10'd1000; ball_x = 10'd630; step();
    n_cmp++;
    if (y_du !== 1'b1 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL paddle_wrap_false: got %b want y_du=1 (%b)", dvec, m_vec());
    end
    ball_x = 10'd1010; step();
    n_cmp++;
    if (y_du !== 1'b0 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL paddle_wide_hit: got %b want y_du=0 (%b)", dvec, m_vec());
    end
    ball_x = 10'd300; ball_y = 10'd200; paddle_x = 10'd0;
  endtask

  task automatic test_brick();
    ball_y = 10'd0; brick_hit = 1; brick_side = 0; step();
    n_cmp++;
    if (y_du !== 1'b1 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL brick_wall_prio0: got %b want y_du=1 (%b)", dvec, m_vec());
    end
    step();
    n_cmp++;
    if (y_du !== 1'b1 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL brick_wall_prio1: got %b want y_du=1 (%b)", dvec, m_vec());
    end
    brick_hit = 0; ball_y = 10'd100; step();
    brick_hit = 1; step();
    brick_hit = 0; step();
    n_cmp++;
    if (y_du !== 1'b0 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL brick_toggle_y: got %b want y_du=0 (%b)", dvec, m_vec());
    end
    ball_x = 10'd639; brick_hit = 1; brick_side = 1; step();
    n_cmp++;
    if (x_du !== 1'b0 || y_du !== 1'b0 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL brick_wall_prio_x: got %b want x_du=0 (%b)", dvec, m_vec());
    end
    ball_x = 10'd300; step();
    n_cmp++;
    if (x_du !== 1'b1 || y_du !== 1'b0 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL brick_toggle_x: got %b want x_du=1 (%b)", dvec, m_vec());
    end
    brick_hit = 0; brick_side = 0; ball_y = 10'd200;
  endtask

  task automatic test_lost();
    logic [1:0] dirs;
    dirs = {x_du, y_du};
    ball_y = 10'd479; step();
    n_cmp++;
    if ({ball_lost, running, move_en} !== 3'b100 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL lost_pulse: got %b want %b", dvec, m_vec());
    end
    launch = 1; ball_y = 10'd200; step();
    n_cmp++;
    if ({ball_lost, running, move_en} !== 3'b000 || {x_du, y_du} !== dirs || dvec !== m_vec()) begin
      n_bad++; $display("FAIL lost_to_idle: got %b want %b", dvec, m_vec());
    end
    launch = 0; step();
    n_cmp++;
    if (running !== 1'b0 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL lost_launch_ignored: got %b want %b", dvec, m_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    launch = 1; step(); launch = 0;
    ball_x = 10'd0; ball_y = 10'd0; step();
    ball_x = 10'd300; ball_y = 10'd200; repeat (5) step();
    resetn = 0; step();
    n_cmp++;
    if (dvec !== 5'b00100 || dvec !== m_vec()) begin
      n_bad++; $display("FAIL reset_mid_run: got %b want %b", dvec, 5'b00100);
    end
    resetn = 1; step();
    n_cmp++;
    if (dvec !== m_vec()) begin
      n_bad++; $display("FAIL reset_hold_idle: got %b want %b", dvec, m_vec());
    end
  endtask

  task automatic test_random();
    int r, bx;
    for (int i = 0; i < 3000; i++) begin
      resetn     = ($urandom_range(0, 299) != 0);
      launch     = ($urandom_range(0, 15) == 0);
      brick_hit  = ($urandom_range(0, 6) == 0);
      brick_side = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0)      bx = 0;
      else if (r == 1) bx = $urandom_range(639, 1023);
      else             bx = $urandom_range(1, 638);
      ball_x = 10'(bx);
      r = $urandom_range(0, 59);
      if (r < 4)       ball_y = 10'd0;
      else if (r < 20) ball_y = 10'd459;
      else if (r == 20) ball_y = 10'($urandom_range(479, 1023));
      else             ball_y = 10'($urandom_range(1, 478));
      paddle_x = (bx >= 40) ? 10'(bx - $urandom_range(0, 80)) : 10'($urandom_range(0, 1023));
      step();
      n_cmp++;
      if (dvec !== m_vec()) begin
        n_bad++; $display("FAIL random i=%0d: got %b want %b", i, dvec, m_vec());
      end
    end
    resetn = 1; quiet_inputs();
  endtask

`ifdef BALL_SPEEDUP_EN
  task automatic test_speedup();
    int period;
    resetn = 0; quiet_inputs(); step(); resetn = 1;
    launch = 1; step(); launch = 0;
    period = 0;
    while (!move_en && period < 300) begin step(); period++; end
    for (int h = 0; h < 4; h++) begin
      if (h == 3) begin
        ball_y = 10'd479; step(); ball_y = 10'd200; step();
        launch = 1; step(); launch = 0;
        period = 0;
        while (!move_en && period < 300) begin step(); period++; end
        period = 0;
      end else begin
        ball_y = 10'd0; step();
        ball_y = 10'd459; paddle_x = 10'd600; ball_x = 10'd630; step();
        ball_y = 10'd200; ball_x = 10'd300;
        period = 2;
      end
      do begin step(); period++; end while (!move_en && period < 300);
      n_cmp++;
      if (period != ((h == 3) ? 64 : 64 - 8 * (h + 1))) begin
        n_bad++; $display("FAIL speedup_period h=%0d: got %0d want %0d", h, period,
                          (h == 3) ? 64 : 64 - 8 * (h + 1));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_launch();
    test_walls();
    test_paddle();
    test_brick();
    test_lost();
    test_reset_mid_run();
    test_random();
`ifdef BALL_SPEEDUP_EN
    test_speedup();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
